// File: rtl/synth_pkg.sv
// Shared definitions for the voice scheduler: register word field positions,
// accumulator guard width and the sequencing FSM states.
package synth_pkg;

    localparam int CFG_BIT   = 31;
    localparam int TUNING_HI = 30;
    localparam int TUNING_LO = 24;
    localparam int ATTACK_HI = 23;
    localparam int ATTACK_LO = 16;
    localparam int DECAY_HI  = 15;
    localparam int DECAY_LO  = 8;
    localparam int NOTE_HI   = 7;
    localparam int NOTE_LO   = 1;
    localparam int GATE_BIT  = 0;

    localparam int ACC_GUARD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/voice_regfile.sv
// Per-slot instrument register file: 16 words, cfg-masked CPU writes, a registered
// CPU read port and a combinational read port for the scheduler.
module voice_regfile
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic        cpu_wen_i,
    input  logic        cpu_ren_i,
    output logic [31:0] cpu_rdata_o,
    input  logic [3:0]  sch_addr_i,
    output logic [30:0] sch_rdata_o
);
    localparam logic [4:0] NV5 = 5'(NUM_VOICES);

    logic [31:0] mem_q [16];
    logic [31:0] rdata_q;
    logic [31:0] wr_word;
    logic        addr_ok;

    assign addr_ok = ({1'b0, cpu_addr_i} < NV5);

    // A cfg=0 write touches only note/gate; the stored cfg bit still follows the write.
    always_comb begin
        wr_word = cpu_wdata_i;
        if (!cpu_wdata_i[CFG_BIT]) begin
            wr_word = {cpu_wdata_i[CFG_BIT],
                       mem_q[cpu_addr_i][TUNING_HI:DECAY_LO],
                       cpu_wdata_i[NOTE_HI:GATE_BIT]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (cpu_wen_i && addr_ok) begin
                mem_q[cpu_addr_i] <= wr_word;
            end
            if (cpu_ren_i) begin
                rdata_q <= addr_ok ? mem_q[cpu_addr_i] : '0;
            end
        end
    end

    assign cpu_rdata_o = rdata_q;
    assign sch_rdata_o = mem_q[sch_addr_i][TUNING_HI:GATE_BIT];

endmodule

// File: rtl/voice_scheduler.sv
// Sample-tick sequencer: issues each slot's parameters to the shared voice engine,
// accumulates the returned samples and emits one saturated mix word per tick.
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int BITDEPTH   = 14,
    parameter int TIMEOUT    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 addr,
    input  logic [31:0]                data_in,
    input  logic                       wen,
    input  logic                       ren,
    output logic                       ready,
    output logic [31:0]                data_out,
    input  logic                       sample_tick,
    output logic [3:0]                 v_index,
    output logic [6:0]                 v_note,
    output logic [6:0]                 v_tuning,
    output logic [7:0]                 v_attack,
    output logic [7:0]                 v_decay,
    output logic                       v_gate,
    output logic                       v_start,
    input  logic signed [BITDEPTH-1:0] v_sample,
    input  logic                       v_valid,
    output logic signed [BITDEPTH-1:0] mix_out,
    output logic                       mix_valid,
    output logic                       overrun,
    output logic                       timeout,
    output state_t                     dbg_state
);
    localparam int ACC_W  = BITDEPTH + ACC_GUARD;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [3:0]              LAST_IDX  = 4'(NUM_VOICES - 1);
    localparam logic [WCNT_W-1:0]       WAIT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((2 ** (BITDEPTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;

    state_t                     state_q, state_d;
    logic [3:0]                 idx_q, idx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [WCNT_W-1:0]          wcnt_q, wcnt_d;
    logic                       timeout_hit, advance;
    logic signed [BITDEPTH-1:0] sat_mix;
    logic [30:0]                slot_word;

    logic                       ready_q, v_start_q, v_gate_q, mix_valid_q, overrun_q, timeout_q;
    logic [6:0]                 v_note_q, v_tuning_q;
    logic [7:0]                 v_attack_q, v_decay_q;
    logic signed [BITDEPTH-1:0] mix_out_q;

    voice_regfile #(.NUM_VOICES(NUM_VOICES)) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .cpu_addr_i  (addr),
        .cpu_wdata_i (data_in),
        .cpu_wen_i   (wen),
        .cpu_ren_i   (ren),
        .cpu_rdata_o (data_out),
        .sch_addr_i  (idx_d),
        .sch_rdata_o (slot_word)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        wcnt_d      = wcnt_q;
        timeout_hit = 1'b0;
        advance     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                    acc_d   = '0;
                    wcnt_d  = '0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                wcnt_d  = '0;
            end
            ST_WAIT: begin
                if (v_valid) begin
                    acc_d   = acc_q + {{ACC_GUARD{v_sample[BITDEPTH-1]}}, v_sample};
                    advance = 1'b1;
                end else if (wcnt_q == WAIT_LAST) begin
                    // Silent engine: the slot contributes nothing and the sweep moves on.
                    timeout_hit = 1'b1;
                    advance     = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (acc_q > SAT_MAX)      sat_mix = SAT_MAX[BITDEPTH-1:0];
        else if (acc_q < SAT_MIN) sat_mix = SAT_MIN[BITDEPTH-1:0];
        else                      sat_mix = acc_q[BITDEPTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            wcnt_q      <= '0;
            ready_q     <= 1'b0;
            v_start_q   <= 1'b0;
            v_note_q    <= '0;
            v_tuning_q  <= '0;
            v_attack_q  <= '0;
            v_decay_q   <= '0;
            v_gate_q    <= 1'b0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            wcnt_q      <= wcnt_d;
            ready_q     <= wen | ren;
            // Parameters are captured on the way into ISSUE so they are stable while v_start is high.
            v_start_q   <= (state_d == ST_ISSUE);
            if (state_d == ST_ISSUE) begin
                v_tuning_q <= slot_word[TUNING_HI:TUNING_LO];
                v_attack_q <= slot_word[ATTACK_HI:ATTACK_LO];
                v_decay_q  <= slot_word[DECAY_HI:DECAY_LO];
                v_note_q   <= slot_word[NOTE_HI:NOTE_LO];
                v_gate_q   <= slot_word[GATE_BIT];
            end
            mix_valid_q <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                mix_out_q <= sat_mix;
            end
            if (sample_tick && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign ready     = ready_q & (wen | ren);
    assign v_index   = idx_q;
    assign v_note    = v_note_q;
    assign v_tuning  = v_tuning_q;
    assign v_attack  = v_attack_q;
    assign v_decay   = v_decay_q;
    assign v_gate    = v_gate_q;
    assign v_start   = v_start_q;
    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: register-file vector table, hand-built tick corner cases
// and randomized ticks scored against a slot-sum reference model.
`timescale 1ns/1ps
module tb_voice_scheduler;
    import synth_pkg::*;

    localparam int NV = 4;
    localparam int BD = 14;
    localparam int TO = 64;

    // ---------------- clock / reset / DUT ----------------
    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [3:0]           addr = '0;
    logic [31:0]          data_in = '0;
    logic                 wen = 1'b0;
    logic                 ren = 1'b0;
    logic                 ready;
    logic [31:0]          data_out;
    logic                 sample_tick = 1'b0;
    logic [3:0]           v_index;
    logic [6:0]           v_note, v_tuning;
    logic [7:0]           v_attack, v_decay;
    logic                 v_gate, v_start;
    logic signed [BD-1:0] v_sample = '0;
    logic                 v_valid = 1'b0;
    logic signed [BD-1:0] mix_out;
    logic                 mix_valid, overrun, timeout;
    state_t               dbg_state;

    always #5 clk = ~clk;

    voice_scheduler #(.NUM_VOICES(NV), .BITDEPTH(BD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wen(wen), .ren(ren),
        .ready(ready), .data_out(data_out), .sample_tick(sample_tick),
        .v_index(v_index), .v_note(v_note), .v_tuning(v_tuning), .v_attack(v_attack),
        .v_decay(v_decay), .v_gate(v_gate), .v_start(v_start), .v_sample(v_sample),
        .v_valid(v_valid), .mix_out(mix_out), .mix_valid(mix_valid), .overrun(overrun),
        .timeout(timeout), .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tick_cyc = 0;
    int mix_cyc  = 0;
    int mix_cnt  = 0;
    logic signed [BD-1:0] last_mix = '0;

    logic [31:0] model_reg [16];
    int          eng_lat = 1;
    int          eng_resp [16];
    bit          eng_silent [16];
    bit          eng_pend = 1'b0;
    int          eng_cnt  = 0;
    int          eng_slot = 0;

    logic [34:0] issue_log [$];
    logic [34:0] exp_issue [16];
    logic [BD-1:0] exp_q [$];
    int          exp_lat = 0;
    int          m_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: answers each v_start after eng_lat cycles unless the slot is silent.
    always @(negedge clk) begin
        v_valid = 1'b0;
        if (rst) begin
            eng_pend = 1'b0;
        end else begin
            if (eng_pend) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_pend = 1'b0;
                    v_valid  = 1'b1;
                    v_sample = BD'(eng_resp[eng_slot]);
                end
            end
            if (v_start) begin
                issue_log.push_back({v_index, v_tuning, v_attack, v_decay, v_note, v_gate});
                eng_slot = int'(v_index);
                if (!eng_silent[v_index]) begin
                    eng_pend = 1'b1;
                    eng_cnt  = eng_lat;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mix_valid) begin
            mix_cnt++;
            last_mix = mix_out;
            mix_cyc  = cyc;
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 800000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- checks ----------------
    task automatic check_hex(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sat(input int s);
        int hi;
        int lo;
        hi = (1 << (BD - 1)) - 1;
        lo = -(1 << (BD - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic logic [34:0] pack_word(input int slot, input logic [31:0] w);
        return {4'(slot), w[30:24], w[23:16], w[15:8], w[7:1], w[0]};
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [31:0] d);
        if (int'(a) < NV) begin
            if (d[31]) model_reg[a] = d;
            else       model_reg[a] = {1'b0, model_reg[a][30:8], d[7:0]};
        end
    endtask

    task automatic expect_snapshot();
        int sum;
        int lat;
        sum = 0;
        lat = 2;
        for (int s = 0; s < NV; s++) begin
            exp_issue[s] = pack_word(s, model_reg[s]);
            if (eng_silent[s]) begin
                lat += 1 + TO;
            end else begin
                lat += 1 + eng_lat;
                sum += eng_resp[s];
            end
        end
        exp_lat = lat;
        exp_q.push_back(BD'(sat(sum)));
        issue_log.delete();
        m_start = mix_cnt;
    endtask

    task automatic await_and_check(input string tag);
        logic [BD-1:0] e;
        for (int k = 0; k < 4000 && mix_cnt == m_start; k++) @(negedge clk);
        check_int({tag, " mix_seen"}, mix_cnt - m_start, 1);
        e = exp_q.pop_front();
        check_int({tag, " mix"}, int'(last_mix), int'($signed(e)));
        check_int({tag, " latency"}, mix_cyc - tick_cyc, exp_lat);
        check_int({tag, " issues"}, issue_log.size(), NV);
        for (int s = 0; s < NV && s < issue_log.size(); s++) begin
            check_hex({tag, " issue"}, 64'(issue_log[s]), 64'(exp_issue[s]));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick_once();
        @(negedge clk);
        sample_tick = 1'b1;
        tick_cyc    = cyc;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic run_tick(input string tag);
        expect_snapshot();
        tick_once();
        await_and_check(tag);
    endtask

    task automatic cpu_access(input bit is_wr, input logic [3:0] a, input logic [31:0] d,
                              output logic [31:0] rd);
        @(negedge clk);
        addr    = a;
        data_in = d;
        wen     = is_wr;
        ren     = !is_wr;
        #1;
        check_hex("ready_wait_state", 64'(ready), 64'd0);
        @(negedge clk);
        check_hex("ready_ack", 64'(ready), 64'd1);
        rd = data_out;
        @(negedge clk);
        wen = 1'b0;
        ren = 1'b0;
        if (is_wr) model_write(a, d);
    endtask

    task automatic set_engine(input int lat, input int r0, input int r1, input int r2, input int r3);
        eng_lat     = lat;
        eng_resp[0] = r0;
        eng_resp[1] = r1;
        eng_resp[2] = r2;
        eng_resp[3] = r3;
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [8];

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] rd;
        int m0;

        tbl[0] = '{4'd2,  32'h80F0_4079, 32'h80F0_4079};
        tbl[1] = '{4'd2,  32'h0000_0032, 32'h00F0_4032};
        tbl[2] = '{4'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[3] = '{4'd0,  32'h0000_0000, 32'h7FFF_FF00};
        tbl[4] = '{4'd3,  32'h1234_5678, 32'h0000_0078};
        tbl[5] = '{4'd5,  32'h80AA_BBCC, 32'h0000_0000};
        tbl[6] = '{4'd15, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[7] = '{4'd1,  32'hA5A5_A5A5, 32'hA5A5_A5A5};

        for (int i = 0; i < 16; i++) begin
            model_reg[i]  = '0;
            eng_resp[i]   = 0;
            eng_silent[i] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_hex("rst ready", 64'(ready), 64'd0);
        check_hex("rst data_out", 64'(data_out), 64'd0);
        check_hex("rst v_params", 64'({v_index, v_note, v_tuning, v_attack, v_decay, v_gate}), 64'd0);
        check_hex("rst v_start", 64'(v_start), 64'd0);
        check_hex("rst mix", 64'({mix_out, mix_valid}), 64'd0);
        check_hex("rst flags", 64'({overrun, timeout}), 64'd0);
        check_hex("rst state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;

        // Register file vectors
        for (int i = 0; i < 8; i++) begin
            cpu_access(1'b1, tbl[i].addr, tbl[i].wdata, rd);
            cpu_access(1'b0, tbl[i].addr, 32'h0, rd);
            check_hex($sformatf("regfile vec%0d", i), 64'(rd), 64'(tbl[i].exp_rd));
        end

        // Full sequence: four slots, latency 3
        cpu_access(1'b1, 4'd0, 32'h8120_3015, rd);
        cpu_access(1'b1, 4'd1, 32'h8221_3127, rd);
        cpu_access(1'b1, 4'd2, 32'h8322_3238, rd);
        cpu_access(1'b1, 4'd3, 32'h8423_334B, rd);
        set_engine(3, 100, 200, -50, 7);
        run_tick("full_seq");
        check_int("full_seq mix_const", int'(last_mix), 257);
        check_int("full_seq lat_const", mix_cyc - tick_cyc, 18);
        @(negedge clk);
        check_hex("params held", 64'({v_index, v_note}), 64'({4'd3, 7'h25}));

        // Write to slot 0 during its ISSUE cycle: old value used, new one next tick
        expect_snapshot();
        @(negedge clk);
        sample_tick = 1'b1;
        tick_cyc    = cyc;
        @(negedge clk);
        sample_tick = 1'b0;
        addr        = 4'd0;
        data_in     = 32'h9A5B_3CE5;
        wen         = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        await_and_check("wr_in_issue");
        model_write(4'd0, 32'h9A5B_3CE5);
        run_tick("wr_next_tick");

        // Saturation both ways
        set_engine(2, 8191, 8191, 8191, 8191);
        run_tick("sat_pos");
        check_int("sat_pos const", int'(last_mix), 8191);
        set_engine(4, -8192, -8192, -8192, -8192);
        run_tick("sat_neg");
        check_int("sat_neg const", int'(last_mix), -8192);

        // Timeout on slot 1
        check_hex("timeout before", 64'(timeout), 64'd0);
        set_engine(2, 11, 999, 22, 33);
        eng_silent[1] = 1'b1;
        run_tick("timeout_seq");
        check_hex("timeout after", 64'(timeout), 64'd1);
        eng_silent[1] = 1'b0;

        // Overrun: second tick during WAIT
        check_hex("overrun before", 64'(overrun), 64'd0);
        set_engine(6, 1, 2, 3, 4);
        expect_snapshot();
        tick_once();
        repeat (3) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        await_and_check("overrun_seq");
        repeat (60) @(negedge clk);
        check_int("overrun single mix", mix_cnt - m_start, 1);
        check_hex("overrun after", 64'(overrun), 64'd1);

        // Reset while waiting on the engine
        set_engine(5, 40, 50, 60, 70);
        m0 = mix_cnt;
        tick_once();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_hex("midrst v_params", 64'({v_index, v_note, v_tuning, v_attack, v_decay, v_gate}), 64'd0);
        check_hex("midrst v_start", 64'(v_start), 64'd0);
        check_hex("midrst mix", 64'({mix_out, mix_valid}), 64'd0);
        check_hex("midrst flags", 64'({overrun, timeout}), 64'd0);
        check_hex("midrst data_out", 64'(data_out), 64'd0);
        check_hex("midrst state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model_reg[i] = '0;
        repeat (80) @(negedge clk);
        check_int("midrst no mix", mix_cnt - m0, 0);
        cpu_access(1'b0, 4'd2, 32'h0, rd);
        check_hex("midrst slot cleared", 64'(rd), 64'd0);
        run_tick("post_rst");

        // Randomized ticks
        for (int it = 0; it < 12; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                cpu_access(1'b1, 4'($urandom_range(0, 15)), $urandom, rd);
            end
            eng_lat = $urandom_range(1, 6);
            for (int s = 0; s < NV; s++) begin
                eng_resp[s]   = ($urandom_range(0, 3) == 0) ? 8191 : int'($urandom_range(0, 16383)) - 8192;
                eng_silent[s] = ($urandom_range(0, 11) == 0);
            end
            run_tick($sformatf("rand%0d", it));
        end
        for (int s = 0; s < NV; s++) begin
            cpu_access(1'b0, 4'(s), 32'h0, rd);
            check_hex($sformatf("rand readback%0d", s), 64'(rd), 64'(model_reg[s]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
